// File: rtl/or_and_sweep_checker_pkg.sv
// Shared definitions for the OR-AND sweep checker: FSM encoding and the
// settle counter width.
package or_and_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int SETTLE_W = 8;

endpackage

// File: rtl/or_and_sweep_checker_golden.sv
// Combinational OR-AND reference function:
//   expected = (OR of vec[N_IN-1:1]) AND vec[0].
module or_and_golden #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] vec_i,
  output logic            expected_o
);

  assign expected_o = (|vec_i[N_IN-1:1]) & vec_i[0];

endmodule

// File: rtl/or_and_sweep_checker.sv
// Sweeps all 2^N_IN vectors onto an external DUT. Each vector is held for
// SETTLE+1 cycles, then the DUT response is compared with the golden model.
//
// state  | meaning
// IDLE   | waiting for start after reset, all results clear
// APPLY  | driving vec, counting down settle, sampling on terminal count
// DONE   | sweep finished, results held until the next start
module or_and_sweep_checker
  import or_and_sweep_checker_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0]     VEC_LAST = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [SETTLE_W-1:0] wait_q, wait_d;
  logic [N_IN:0]       err_q, err_d;
  logic [N_IN-1:0]     ffv_q, ffv_d;
  logic                ffval_q, ffval_d;
  logic                expected;

  or_and_golden #(.N_IN(N_IN)) u_golden (
    .vec_i      (vec_q),
    .expected_o (expected)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          vec_d   = '0;
          wait_d  = SETTLE_C;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
        end
      end
      ST_APPLY: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          // Comparison uses the vector still on the bus; the increment lands on the same edge.
          if (dut_out != expected) begin
            err_d = err_q + 1'b1;
            if (!ffval_q) begin
              ffv_d   = vec_q;
              ffval_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d  = vec_q + 1'b1;
            wait_d = SETTLE_C;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dut_in           = vec_q;
  assign busy             = (state_q == ST_APPLY);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_or_and_sweep_checker.sv
// Scoreboard bench for or_and_sweep_checker: three instances (N3/S0, N3/S1,
// N4/S0) driven by modelled DUTs; expected sweep results come from a reference model.
module tb_or_and_sweep_checker;

  localparam int M_CORRECT = 0, M_STUCK0 = 1, M_STUCK1 = 2, M_INV = 3,
                 M_TABLE = 4, M_REG = 5;
  localparam int BUDGET = 300;

  typedef struct packed {
    int id; int cycles; int err; int ffvalid; int ffv; int pass;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_vec[3];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 0, start_b = 0, start_c = 0;
  int          mode_a = 0, mode_b = 0, mode_c = 0;
  logic [15:0] tbl_a = 0, tbl_b = 0, tbl_c = 0;
  logic        reg_a = 0, reg_b = 0, reg_c = 0;

  logic [2:0] dut_in_a, dut_in_b, ffv_a, ffv_b;
  logic [3:0] dut_in_c, ffv_c, err_a, err_b;
  logic [4:0] err_c;
  logic       dut_out_a, dut_out_b, dut_out_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c, ffval_a, ffval_b, ffval_c;

  function automatic logic gold(int v);
    return ((v >> 1) != 0) && ((v & 1) == 1);
  endfunction

  function automatic logic resp(int mode, int v, logic [15:0] tbl, logic regv);
    case (mode)
      M_CORRECT: return gold(v);
      M_STUCK0:  return 1'b0;
      M_STUCK1:  return 1'b1;
      M_INV:     return !gold(v);
      M_TABLE:   return tbl[v];
      default:   return regv;
    endcase
  endfunction

  function automatic int nb(int id);
    return (id == 2) ? 4 : 3;
  endfunction

  function automatic int st(int id);
    return (id == 1) ? 1 : 0;
  endfunction

  assign dut_out_a = resp(mode_a, int'(dut_in_a), tbl_a, reg_a);
  assign dut_out_b = resp(mode_b, int'(dut_in_b), tbl_b, reg_b);
  assign dut_out_c = resp(mode_c, int'(dut_in_c), tbl_c, reg_c);

  // One-cycle-latency DUT model.
  always @(posedge clk) begin
    reg_a <= gold(int'(dut_in_a));
    reg_b <= gold(int'(dut_in_b));
    reg_c <= gold(int'(dut_in_c));
  end

  or_and_sweep_checker #(.N_IN(3), .SETTLE(0)) u_dut_a (
    .clk(clk), .reset(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffval_a));

  or_and_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut_b (
    .clk(clk), .reset(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffval_b));

  or_and_sweep_checker #(.N_IN(4), .SETTLE(0)) u_dut_c (
    .clk(clk), .reset(rst), .start(start_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ffv_c), .first_fail_valid(ffval_c));

  int din_v[3], err_v[3], ffv_v[3];
  bit busy_v[3], done_v[3], pass_v[3], ffval_v[3];

  always_comb begin
    din_v[0] = int'(dut_in_a); din_v[1] = int'(dut_in_b); din_v[2] = int'(dut_in_c);
    err_v[0] = int'(err_a);    err_v[1] = int'(err_b);    err_v[2] = int'(err_c);
    ffv_v[0] = int'(ffv_a);    ffv_v[1] = int'(ffv_b);    ffv_v[2] = int'(ffv_c);
    busy_v[0] = busy_a;  busy_v[1] = busy_b;  busy_v[2] = busy_c;
    done_v[0] = done_a;  done_v[1] = done_b;  done_v[2] = done_c;
    pass_v[0] = pass_a;  pass_v[1] = pass_b;  pass_v[2] = pass_c;
    ffval_v[0] = ffval_a; ffval_v[1] = ffval_b; ffval_v[2] = ffval_c;
  end

  task automatic check(string name, int act, int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: walk every vector, apply the modelled DUT behaviour.
  function automatic exp_t model(int id, int mode, logic [15:0] tbl, int prev);
    exp_t e;
    int   n = nb(id);
    int   s = st(id);
    e = '0;
    e.id = id;
    e.cycles = (1 << n) * (s + 1);
    for (int k = 0; k < (1 << n); k++) begin
      logic g, r;
      g = gold(k);
      case (mode)
        M_CORRECT: r = g;
        M_STUCK0:  r = 1'b0;
        M_STUCK1:  r = 1'b1;
        M_INV:     r = !g;
        M_TABLE:   r = tbl[k];
        default:   r = (s > 0) ? g : gold((k == 0) ? prev : k - 1);
      endcase
      if (r != g) begin
        if (e.ffvalid == 0) begin
          e.ffvalid = 1;
          e.ffv = k;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  int cnt[3];
  bit busy_p[3], done_p[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_v[i]) begin
        if (!busy_p[i]) cnt[i] = 0;
        check($sformatf("dut_in_step[%0d]", i), din_v[i], cnt[i] / (st(i) + 1));
        check($sformatf("done_low_while_busy[%0d]", i), int'(done_v[i]), 0);
        cnt[i]++;
      end
      if (done_v[i] && !done_p[i]) begin
        check($sformatf("done_after_busy[%0d]", i), int'(busy_p[i]), 1);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done[%0d]: got done with empty scoreboard", i);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_instance", i, e.id);
          check($sformatf("busy_cycles[%0d]", i), cnt[i], e.cycles);
          check($sformatf("err_count[%0d]", i), err_v[i], e.err);
          check($sformatf("ff_valid[%0d]", i), int'(ffval_v[i]), e.ffvalid);
          check($sformatf("ff_vec[%0d]", i), ffv_v[i], e.ffv);
          check($sformatf("pass[%0d]", i), int'(pass_v[i]), e.pass);
        end
      end
      busy_p[i] = busy_v[i];
      done_p[i] = done_v[i];
    end
  end

  task automatic set_start(int id, logic v);
    case (id)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic set_mode(int id, int mode, logic [15:0] tbl);
    case (id)
      0: begin mode_a = mode; tbl_a = tbl; end
      1: begin mode_b = mode; tbl_b = tbl; end
      default: begin mode_c = mode; tbl_c = tbl; end
    endcase
  endtask

  task automatic wait_done(int id);
    int k = 0;
    while (!done_v[id] && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    if (!done_v[id]) begin
      check($sformatf("done_timeout[%0d]", id), int'(done_v[id]), 1);
      sb_q.delete();
    end else begin
      last_vec[id] = (1 << nb(id)) - 1;
    end
    @(negedge clk);
  endtask

  task automatic issue(int id, int mode, logic [15:0] tbl);
    set_mode(id, mode, tbl);
    sb_q.push_back(model(id, mode, tbl, last_vec[id]));
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  task automatic check_a_clear(string tag);
    check({tag, "_dut_in"}, int'(dut_in_a), 0);
    check({tag, "_busy"}, int'(busy_a), 0);
    check({tag, "_done"}, int'(done_a), 0);
    check({tag, "_pass"}, int'(pass_a), 0);
    check({tag, "_err"}, int'(err_a), 0);
    check({tag, "_ffv"}, int'(ffv_a), 0);
    check({tag, "_ffval"}, int'(ffval_a), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) last_vec[i] = 0;
    #12;
    check_a_clear("reset");
    check("reset_c_err", int'(err_c), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(0, M_CORRECT, '0); wait_done(0);
    issue(0, M_STUCK0, '0);  wait_done(0);
    issue(0, M_INV, '0);     wait_done(0);
    issue(1, M_REG, '0);     wait_done(1);
    issue(0, M_REG, '0);     wait_done(0);

    // start pulsed again during busy must be ignored
    issue(0, M_STUCK0, '0);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0);

    // restart from DONE clears results on the start edge
    issue(0, M_CORRECT, '0);
    check("restart_err", int'(err_a), 0);
    check("restart_done", int'(done_a), 0);
    check("restart_ffval", int'(ffval_a), 0);
    check("restart_busy", int'(busy_a), 1);
    wait_done(0);

    // reset in the middle of a sweep aborts it
    set_mode(0, M_STUCK0, '0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_a_clear("abort");
    sb_q.delete();
    for (int i = 0; i < 3; i++) last_vec[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, M_STUCK0, '0); wait_done(0);

    issue(2, M_STUCK1, '0);  wait_done(2);
    issue(2, M_CORRECT, '0); wait_done(2);

    for (int r = 0; r < 9; r++) begin
      logic [15:0] t;
      t = 16'($urandom);
      issue(r % 3, M_TABLE, t);
      wait_done(r % 3);
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
